// File: rtl/audio_pkg.sv
// Shared audio-path definitions: clock generator states and default timing
// constants, also used by the I2S transmitter (32-bit slot counter).
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } clk_state_t;

    localparam int DEF_MCLK_DIV      = 4;
    localparam int DEF_BCLK_DIV      = 16;
    localparam int DEF_SLOT_BITS     = 32;
    localparam int DEF_FRAME_SAMPLES = 800;

    // A modulus of 1 would give a zero-width counter, so clamp to one bit.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/clk_div_even.sv
// Even-ratio 50% duty clock divider with a terminal-count strobe that is high
// in the cycle before the counter wraps, i.e. just before clk_out falls.
module clk_div_even
    import audio_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic Clk50,
    input  logic reset_n,
    input  logic run,
    output logic clk_out,
    output logic tc
);

    localparam int             W      = cnt_width(DIV);
    localparam logic [W-1:0]   LAST   = W'(DIV - 1);
    localparam logic [W-1:0]   HALF   = W'(DIV / 2);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = '0;
        tc       = run && (cnt == LAST);
        if (run && (cnt != LAST)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // clk_out is decoded from the next count so the pin is a plain flop output.
    always_ff @(posedge Clk50) begin
        if (!reset_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            clk_out <= (cnt_next >= HALF);
        end
    end

endmodule

// File: rtl/i2s_clkgen.sv
// Audio timing master: MClk, SClk and LRClk from Clk50, plus sample and frame
// strobes. Stopping always waits for the end of the current LR period.
module i2s_clkgen
    import audio_pkg::*;
#(
    parameter int MCLK_DIV      = DEF_MCLK_DIV,
    parameter int BCLK_DIV      = DEF_BCLK_DIV,
    parameter int SLOT_BITS     = DEF_SLOT_BITS,
    parameter int FRAME_SAMPLES = DEF_FRAME_SAMPLES
) (
    input  logic Clk50,
    input  logic reset_n,
    input  logic enable,
    output logic MClk,
    output logic SClk,
    output logic LRClk,
    output logic sample_tick,
    output logic new_frame,
    output logic running
);

    localparam int              BITS       = 2 * SLOT_BITS;
    localparam int              BW         = cnt_width(BITS);
    localparam int              FW         = cnt_width(FRAME_SAMPLES);
    localparam logic [BW-1:0]   BIT_LAST   = BW'(BITS - 1);
    localparam logic [BW-1:0]   SLOT_START = BW'(SLOT_BITS);
    localparam logic [FW-1:0]   FRAME_LAST = FW'(FRAME_SAMPLES - 1);

    clk_state_t    state;
    clk_state_t    state_next;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_cnt_next;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] frame_cnt_next;
    logic          active;
    logic          bclk_tc;
    logic          mclk_tc_unused;
    logic          lr_wrap;
    logic          tick_next;
    logic          frame_next;

    assign active = (state != IDLE);

    clk_div_even #(
        .DIV (MCLK_DIV)
    ) u_mclk_div (
        .Clk50   (Clk50),
        .reset_n (reset_n),
        .run     (active),
        .clk_out (MClk),
        .tc      (mclk_tc_unused)
    );

    clk_div_even #(
        .DIV (BCLK_DIV)
    ) u_bclk_div (
        .Clk50   (Clk50),
        .reset_n (reset_n),
        .run     (active),
        .clk_out (SClk),
        .tc      (bclk_tc)
    );

    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        frame_cnt_next = frame_cnt;
        tick_next      = 1'b0;
        frame_next     = 1'b0;
        lr_wrap        = bclk_tc && (bit_cnt == BIT_LAST);

        if (bclk_tc) begin
            bit_cnt_next = lr_wrap ? '0 : bit_cnt + 1'b1;
        end

        // frame_cnt keeps counting while draining; only the pulse is withheld.
        if (lr_wrap) begin
            tick_next      = 1'b1;
            frame_cnt_next = (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
            frame_next     = (frame_cnt == FRAME_LAST) && (state == RUN);
        end

        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_next = RUN;
                end else if (lr_wrap) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next == IDLE) begin
            bit_cnt_next   = '0;
            frame_cnt_next = '0;
        end
    end

    always_ff @(posedge Clk50) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            frame_cnt   <= '0;
            LRClk       <= 1'b0;
            sample_tick <= 1'b0;
            new_frame   <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            frame_cnt   <= frame_cnt_next;
            LRClk       <= (bit_cnt_next >= SLOT_START);
            sample_tick <= tick_next;
            new_frame   <= frame_next;
            running     <= (state_next != IDLE);
        end
    end

endmodule
